// File: rtl/uxn_mem_arbiter.sv
// rtl/uxn_mem_arbiter.sv - round-robin arbiter serialising byte/short requests onto the single-port main memory
// Each granted transaction becomes one or two byte beats; short transfers are big-endian.
module uxn_mem_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ-1:0]        short_m,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*16-1:0]     wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [15:0]               rdata,
  output logic                      busy,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [7:0]                mem_wdata,
  input  logic [7:0]                mem_rdata
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

  state_t            state, state_nx;
  logic [PW-1:0]     ptr, ptr_nx, win;
  logic              win_ok;
  logic [NUM_REQ-1:0] req_rot;
  logic [PW:0]       sum;
  logic [PW:0]       nsum;

  logic              l_we, l_short;
  logic [ADDR_W-1:0] l_addr;
  logic [15:0]       l_wdata;
  logic [7:0]        hi_byte;

  // Rotate requests so bit 0 is the requester at the pointer; lowest set bit wins.
  always_comb begin
    req_rot = NUM_REQ'({req, req} >> ptr);
    win_ok  = 1'b0;
    win     = '0;
    sum     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        win_ok = 1'b1;
        sum    = {1'b0, ptr} + (PW+1)'(k);
        if (sum >= (PW+1)'(NUM_REQ)) begin
          sum = sum - (PW+1)'(NUM_REQ);
        end
        win = sum[PW-1:0];
      end
    end
  end

  always_comb begin
    nsum = {1'b0, win} + (PW+1)'(1);
    if (nsum >= (PW+1)'(NUM_REQ)) begin
      nsum = '0;
    end
    ptr_nx = nsum[PW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt     <= '0;
      l_we    <= 1'b0;
      l_short <= 1'b0;
      l_addr  <= '0;
      l_wdata <= '0;
      hi_byte <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (win_ok) begin
            l_we    <= we[win];
            l_short <= short_m[win];
            l_addr  <= addr[int'(win)*ADDR_W +: ADDR_W];
            l_wdata <= wdata[int'(win)*16 +: 16];
            gnt     <= NUM_REQ'(1) << win;
            ptr     <= ptr_nx;
          end
        end
        ACC1: begin
          if (!l_we) begin
            hi_byte <= mem_rdata;
          end
        end
        DONE: gnt <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    done      = '0;
    rdata     = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (win_ok) begin
          state_nx = ACC0;
        end
      end
      ACC0: begin
        mem_en    = 1'b1;
        mem_we    = l_we;
        mem_addr  = l_addr;
        mem_wdata = l_short ? l_wdata[15:8] : l_wdata[7:0];
        state_nx  = l_short ? ACC1 : DONE;
      end
      ACC1: begin
        mem_en    = 1'b1;
        mem_we    = l_we;
        mem_addr  = l_addr + ADDR_W'(1);
        mem_wdata = l_wdata[7:0];
        state_nx  = DONE;
      end
      DONE: begin
        done = gnt;
        if (!l_we) begin
          rdata = l_short ? {hi_byte, mem_rdata} : {8'h00, mem_rdata};
        end
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uxn_mem_arbiter.sv
// tb/tb_uxn_mem_arbiter.sv - self-checking bench for uxn_mem_arbiter
// Transaction-level model: round-robin pointer, byte-array memory image, fixed beat latency.
module tb_uxn_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req, we, short_m;
  logic [47:0] addr;
  logic [47:0] wdata;
  logic [2:0]  gnt, done;
  logic [15:0] rdata;
  logic        busy, mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];

  int vectors;
  int miscompares;
  int rr;

  uxn_mem_arbiter #(.NUM_REQ(3), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .short_m(short_m),
    .addr(addr), .wdata(wdata), .gnt(gnt), .done(done), .rdata(rdata),
    .busy(busy), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int i, input bit w, input bit s, input logic [15:0] a, input logic [15:0] d);
    we[i]            = w;
    short_m[i]       = s;
    addr[i*16 +: 16] = a;
    wdata[i*16 +: 16] = d;
  endtask

  function automatic int model_winner();
    for (int k = 0; k < 3; k++) begin
      if (req[(rr + k) % 3]) return (rr + k) % 3;
    end
    return -1;
  endfunction

  // One arbitration round from an IDLE sample point to the following IDLE.
  task automatic step(input int exp_w, input bit hold, input bit perturb);
    int          w;
    bit          wr, sh;
    logic [15:0] a, a1, d, exp_rd;
    check("idle_busy", busy, 0);
    check("idle_gnt", gnt, 0);
    w  = (exp_w >= 0) ? exp_w : model_winner();
    wr = we[w];
    sh = short_m[w];
    a  = addr[w*16 +: 16];
    d  = wdata[w*16 +: 16];
    a1 = a + 16'd1;
    if (wr) exp_rd = 16'h0000;
    else if (sh) exp_rd = {ref_mem[a], ref_mem[a1]};
    else exp_rd = {8'h00, ref_mem[a]};
    tick();
    check("acc0_gnt", gnt, 3'b001 << w);
    check("acc0_busy", busy, 1);
    check("acc0_en", mem_en, 1);
    check("acc0_we", mem_we, wr);
    check("acc0_addr", mem_addr, a);
    if (wr) check("acc0_wdata", mem_wdata, sh ? d[15:8] : d[7:0]);
    check("acc0_done", done, 0);
    if (perturb) begin
      addr[w*16 +: 16]  = 16'($urandom);
      wdata[w*16 +: 16] = 16'($urandom);
      we[w]             = 1'($urandom);
      short_m[w]        = 1'($urandom);
      if ($urandom_range(0, 1) == 1) req[w] = 1'b0;
    end
    if (sh) begin
      tick();
      check("acc1_gnt", gnt, 3'b001 << w);
      check("acc1_en", mem_en, 1);
      check("acc1_addr", mem_addr, a1);
      check("acc1_we", mem_we, wr);
      if (wr) check("acc1_wdata", mem_wdata, d[7:0]);
      check("acc1_done", done, 0);
    end
    tick();
    check("done_pulse", done, 3'b001 << w);
    check("done_rdata", rdata, exp_rd);
    check("done_en", mem_en, 0);
    check("done_busy", busy, 1);
    if (wr) begin
      if (sh) begin
        ref_mem[a]  = d[15:8];
        ref_mem[a1] = d[7:0];
      end else begin
        ref_mem[a] = d[7:0];
      end
    end
    if (!hold) req[w] = 1'b0;
    rr = (w + 1) % 3;
    tick();
    check("post_done", done, 0);
  endtask

  initial begin
    int          diffs;
    logic [7:0]  v;
    vectors     = 0;
    miscompares = 0;
    rr          = 0;
    rst     = 1'b1;
    req     = '0;
    we      = '0;
    short_m = '0;
    addr    = '0;
    wdata   = '0;
    for (int i = 0; i < 65536; i++) begin
      v = 8'($urandom);
      mem[i]     = v;
      ref_mem[i] = v;
    end
    mem[16'h0100] = 8'hAB; ref_mem[16'h0100] = 8'hAB;
    mem[16'hFFFF] = 8'hCA; ref_mem[16'hFFFF] = 8'hCA;
    mem[16'h0000] = 8'hFE; ref_mem[16'h0000] = 8'hFE;

    #1;
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rdata", rdata, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("idle_no_req_en", mem_en, 0);

    // byte read from requester 0
    set_ops(0, 0, 0, 16'h0100, 16'h0000);
    req = 3'b001;
    step(0, 0, 0);
    check("byte_read_rdata_const", {ref_mem[16'h0100]}, 8'hAB);

    // short write from requester 1
    set_ops(1, 1, 1, 16'h0200, 16'h1234);
    req = 3'b010;
    step(1, 0, 0);
    check("short_write_hi", mem[16'h0200], 8'h12);
    check("short_write_lo", mem[16'h0201], 8'h34);

    // short read wrapping from 0xFFFF to 0x0000
    set_ops(2, 0, 1, 16'hFFFF, 16'h0000);
    req = 3'b100;
    step(2, 0, 0);

    // round-robin with all requests held
    set_ops(0, 0, 0, 16'h0010, 16'h0000);
    set_ops(1, 0, 0, 16'h0011, 16'h0000);
    set_ops(2, 0, 0, 16'h0012, 16'h0000);
    req = 3'b111;
    step(0, 1, 0);
    step(1, 1, 0);
    step(2, 1, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    req = 3'b000;
    tick();

    // pointer behaviour
    req = 3'b001;
    step(0, 0, 0);
    req = 3'b110;
    step(1, 0, 0);
    step(2, 0, 0);
    req = 3'b010;
    step(1, 0, 0);
    req = 3'b011;
    step(0, 0, 0);
    step(1, 0, 0);

    // reset during the second beat of a short write
    set_ops(0, 1, 1, 16'h0300, 16'h5566);
    req = 3'b001;
    tick();
    tick();
    check("pre_rst_addr", mem_addr, 16'h0301);
    rst = 1'b1;
    #1;
    check("midrst_en", mem_en, 0);
    check("midrst_gnt", gnt, 0);
    check("midrst_done", done, 0);
    check("midrst_busy", busy, 0);
    ref_mem[16'h0300] = 8'h55;
    set_ops(0, 0, 0, 16'h0020, 16'h0000);
    set_ops(2, 0, 0, 16'h0022, 16'h0000);
    req = 3'b101;
    tick();
    check("rst_held_en", mem_en, 0);
    check("rst_held_done", done, 0);
    rst = 1'b0;
    rr  = 0;
    step(0, 0, 0);
    step(2, 0, 0);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          set_ops(i, 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'(16'h0400 + $urandom_range(0, 15)),
                  16'($urandom));
          req[i] = 1'b1;
        end
      end
      if (req == 3'b000) begin
        tick();
        check("rand_idle_busy", busy, 0);
      end else begin
        step(-1, 0, 1);
      end
    end
    req = '0;
    tick();

    diffs = 0;
    for (int i = 0; i < 65536; i++) begin
      if (mem[i] !== ref_mem[i]) diffs++;
    end
    check("mem_image_diffs", diffs, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
